// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared FSM state type and default operand width
package serial_add_pkg;
  localparam int DEFAULT_WIDTH = 8;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/serial_add_sequencer_if.sv
// serial_add_sequencer_if: operand/result handshake bundle
// master drives in_valid/a_in/b_in/out_ready; slave drives in_ready/out_valid/sum_out/carry_out/busy
interface serial_add_sequencer_if #(parameter int WIDTH = serial_add_pkg::DEFAULT_WIDTH);
  logic in_valid, in_ready, out_valid, out_ready, carry_out, busy;
  logic [WIDTH-1:0] a_in, b_in, sum_out;
  modport master (output in_valid, a_in, b_in, out_ready, input in_ready, out_valid, sum_out, carry_out, busy);
  modport slave (input in_valid, a_in, b_in, out_ready, output in_ready, out_valid, sum_out, carry_out, busy);
endinterface

// File: rtl/serial_add_bit.sv
// serial_add_bit: 1-bit full adder with carry flip-flop
// clk/rst_n: clock, async active-low reset; i_a/i_b: operand bits; i_clr: sync carry clear;
// i_en: carry update enable; o_sum/o_cout: combinational sum and carry-out
module serial_add_bit (
  input  logic clk,
  input  logic rst_n,
  input  logic i_a,
  input  logic i_b,
  input  logic i_clr,
  input  logic i_en,
  output logic o_sum,
  output logic o_cout
);
  logic r_c;
  assign o_sum = i_a ^ i_b ^ r_c;
  assign o_cout = (i_a & i_b) | (r_c & (i_a ^ i_b));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_c <= 1'b0;
    else r_c <= i_clr ? 1'b0 : i_en ? o_cout : r_c;
endmodule

// File: rtl/serial_add_sequencer.sv
// serial_add_sequencer: bit-serial adder with valid/ready handshake, one bit per cycle LSB first
// clk: clock; rst: async active-low reset; bus: slave side of serial_add_sequencer_if
module serial_add_sequencer #(parameter int WIDTH = serial_add_pkg::DEFAULT_WIDTH) (
  input logic clk,
  input logic rst,
  serial_add_sequencer_if.slave bus
);
  import serial_add_pkg::*;
  localparam int CW = $clog2(WIDTH + 1);
  state_t r_state;
  logic [WIDTH-1:0] r_a, r_b, r_res, r_sum;
  logic [CW-1:0] r_cnt;
  logic r_carry, r_out_valid, w_s, w_c, w_shift, w_accept, w_last;
  assign w_shift = r_state == SHIFT;
  assign w_accept = bus.in_valid && bus.in_ready;
  assign w_last = r_cnt == CW'(WIDTH - 1);
  assign bus.in_ready = (r_state == IDLE) && rst;
  assign bus.busy = r_state != IDLE;
  assign bus.out_valid = r_out_valid;
  assign bus.sum_out = r_sum;
  assign bus.carry_out = r_carry;
  serial_add_bit u_bit (
    .clk(clk), .rst_n(rst), .i_a(r_a[0]), .i_b(r_b[0]),
    .i_clr(w_accept), .i_en(w_shift), .o_sum(w_s), .o_cout(w_c)
  );
  // result bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB;
  // the published sum/carry only update on the final shift so no partial value is visible
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_a <= '0;
      r_b <= '0;
      r_res <= '0;
      r_sum <= '0;
      r_cnt <= '0;
      r_carry <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_a <= bus.a_in;
          r_b <= bus.b_in;
          r_cnt <= '0;
          r_state <= SHIFT;
        end
        SHIFT: begin
          r_a <= r_a >> 1;
          r_b <= r_b >> 1;
          r_res <= {w_s, r_res[WIDTH-1:1]};
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_sum <= {w_s, r_res[WIDTH-1:1]};
            r_carry <= w_c;
            r_out_valid <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: if (bus.out_ready) begin
          r_out_valid <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_add_sequencer.sv
// tb_serial_add_sequencer: randomized self-checking bench against an arithmetic reference
module tb_serial_add_sequencer;
  localparam int W8 = 8;
  localparam int W4 = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0;
  int bad = 0;
  serial_add_sequencer_if #(.WIDTH(W8)) bus8 ();
  serial_add_sequencer_if #(.WIDTH(W4)) bus4 ();
  serial_add_sequencer #(.WIDTH(W8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  serial_add_sequencer #(.WIDTH(W4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  always #5 clk = ~clk;

  task automatic run8(input logic [7:0] a, input logic [7:0] b, output int lat, output bit to);
    int n = 0;
    @(negedge clk);
    bus8.a_in = a;
    bus8.b_in = b;
    bus8.in_valid = 1'b1;
    while (!bus8.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    bus8.in_valid = 1'b0;
    lat = 1;
    while (!bus8.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    to = !bus8.out_valid;
  endtask

  task automatic ack8;
    bus8.out_ready = 1'b1;
    @(negedge clk);
    bus8.out_ready = 1'b0;
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b, output bit to);
    int n = 0;
    int lat = 0;
    @(negedge clk);
    bus4.a_in = a;
    bus4.b_in = b;
    bus4.in_valid = 1'b1;
    while (!bus4.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    bus4.in_valid = 1'b0;
    while (!bus4.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    to = !bus4.out_valid;
  endtask

  task automatic test_reset;
    @(negedge clk);
    total++;
    if ({bus8.out_valid, bus8.in_ready, bus8.busy, bus8.carry_out} !== 4'b0000 || bus8.sum_out !== 8'h00) begin
      bad++;
      $display("FAIL reset_state: ov/ir/busy/c=%b sum=%h, want 0000 sum=00",
               {bus8.out_valid, bus8.in_ready, bus8.busy, bus8.carry_out}, bus8.sum_out);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (bus8.in_ready !== 1'b1 || bus4.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_ready: in_ready8=%b in_ready4=%b, want 1 1", bus8.in_ready, bus4.in_ready);
    end
  endtask

  task automatic test_basic;
    int lat;
    bit to;
    logic [8:0] exp = 9'h05A + 9'h033;
    run8(8'h5A, 8'h33, lat, to);
    total++;
    if (to || lat != W8 + 1) begin
      bad++;
      $display("FAIL basic_latency: edges=%0d timeout=%0b, want %0d", lat, to, W8 + 1);
    end
    total++;
    if ({bus8.carry_out, bus8.sum_out} !== exp) begin
      bad++;
      $display("FAIL basic_sum: got c=%b s=%h, want c=%b s=%h", bus8.carry_out, bus8.sum_out, exp[8], exp[7:0]);
    end
    ack8();
    total++;
    if (bus8.out_valid !== 1'b0 || bus8.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL basic_return_idle: out_valid=%b in_ready=%b, want 0 1", bus8.out_valid, bus8.in_ready);
    end
  endtask

  task automatic test_overflow;
    int lat;
    bit to;
    logic [8:0] exp = 9'h0FF + 9'h001;
    run8(8'hFF, 8'h01, lat, to);
    total++;
    if (to || {bus8.carry_out, bus8.sum_out} !== exp) begin
      bad++;
      $display("FAIL overflow: got c=%b s=%h timeout=%0b, want c=%b s=%h", bus8.carry_out, bus8.sum_out, to, exp[8], exp[7:0]);
    end
    ack8();
  endtask

  task automatic test_carry_isolation;
    int lat;
    bit to;
    logic [7:0] av [2] = '{8'hFF, 8'h00};
    logic [7:0] bv [2] = '{8'hFF, 8'h00};
    for (int i = 0; i < 2; i++) begin
      logic [8:0] exp = {1'b0, av[i]} + {1'b0, bv[i]};
      run8(av[i], bv[i], lat, to);
      total++;
      if (to || {bus8.carry_out, bus8.sum_out} !== exp) begin
        bad++;
        $display("FAIL carry_isolation_%0d: got c=%b s=%h, want c=%b s=%h", i, bus8.carry_out, bus8.sum_out, exp[8], exp[7:0]);
      end
      ack8();
    end
  endtask

  task automatic test_random;
    int lat;
    bit to;
    for (int i = 0; i < 12; i++) begin
      logic [7:0] a = 8'($urandom);
      logic [7:0] b = 8'($urandom);
      logic [8:0] exp = {1'b0, a} + {1'b0, b};
      run8(a, b, lat, to);
      total++;
      if (to || lat != W8 + 1 || {bus8.carry_out, bus8.sum_out} !== exp) begin
        bad++;
        $display("FAIL random_%0d: %h+%h got c=%b s=%h lat=%0d, want c=%b s=%h lat=%0d",
                 i, a, b, bus8.carry_out, bus8.sum_out, lat, exp[8], exp[7:0], W8 + 1);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      ack8();
    end
  endtask

  task automatic test_stall;
    int lat;
    bit to;
    logic [7:0] a = 8'($urandom);
    logic [7:0] b = 8'($urandom);
    logic [8:0] exp = {1'b0, a} + {1'b0, b};
    run8(a, b, lat, to);
    total++;
    if (to) begin
      bad++;
      $display("FAIL stall_start: out_valid never rose, want 1");
    end
    bus8.in_valid = 1'b1;
    bus8.a_in = 8'h11;
    bus8.b_in = 8'($urandom);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({bus8.carry_out, bus8.sum_out} !== exp || bus8.out_valid !== 1'b1 || bus8.in_ready !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold_%0d: c=%b s=%h ov=%b ir=%b, want c=%b s=%h ov=1 ir=0",
                 i, bus8.carry_out, bus8.sum_out, bus8.out_valid, bus8.in_ready, exp[8], exp[7:0]);
      end
    end
    bus8.in_valid = 1'b0;
    ack8();
    @(negedge clk);
    total++;
    if (bus8.busy !== 1'b0 || bus8.out_valid !== 1'b0 || {bus8.carry_out, bus8.sum_out} !== exp) begin
      bad++;
      $display("FAIL stall_no_accept: busy=%b ov=%b c=%b s=%h, want busy=0 ov=0 c=%b s=%h",
               bus8.busy, bus8.out_valid, bus8.carry_out, bus8.sum_out, exp[8], exp[7:0]);
    end
  endtask

  task automatic test_reset_abort;
    int lat;
    bit to;
    bit seen = 1'b0;
    logic [8:0] exp = 9'h010 + 9'h020;
    @(negedge clk);
    bus8.a_in = 8'hC3;
    bus8.b_in = 8'h5A;
    bus8.in_valid = 1'b1;
    @(negedge clk);
    bus8.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (bus8.busy !== 1'b1) begin
      bad++;
      $display("FAIL abort_in_shift: busy=%b, want 1", bus8.busy);
    end
    rst = 1'b0;
    #1;
    total++;
    if ({bus8.out_valid, bus8.in_ready, bus8.busy, bus8.carry_out} !== 4'b0000 || bus8.sum_out !== 8'h00) begin
      bad++;
      $display("FAIL abort_async: ov/ir/busy/c=%b sum=%h, want 0000 sum=00",
               {bus8.out_valid, bus8.in_ready, bus8.busy, bus8.carry_out}, bus8.sum_out);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (bus8.in_ready !== 1'b1 || bus8.busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_release: in_ready=%b busy=%b, want 1 0", bus8.in_ready, bus8.busy);
    end
    repeat (W8 + 4) begin
      @(negedge clk);
      if (bus8.out_valid) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL abort_no_partial: out_valid seen=1, want 0");
    end
    run8(8'h10, 8'h20, lat, to);
    total++;
    if (to || {bus8.carry_out, bus8.sum_out} !== exp) begin
      bad++;
      $display("FAIL abort_recover: got c=%b s=%h, want c=%b s=%h", bus8.carry_out, bus8.sum_out, exp[8], exp[7:0]);
    end
    ack8();
  endtask

  task automatic test_exhaustive4;
    bit to;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        int exp = a + b;
        run4(4'(a), 4'(b), to);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        total++;
        if (to || {bus4.carry_out, bus4.sum_out} !== 5'(exp)) begin
          bad++;
          $display("FAIL exh4 %0d+%0d: got %0d timeout=%0b, want %0d", a, b, {bus4.carry_out, bus4.sum_out}, to, exp);
        end
        bus4.out_ready = 1'b1;
        @(negedge clk);
        bus4.out_ready = 1'b0;
      end
    end
  endtask

  initial begin
    bus8.in_valid = 1'b0;
    bus8.out_ready = 1'b0;
    bus8.a_in = '0;
    bus8.b_in = '0;
    bus4.in_valid = 1'b0;
    bus4.out_ready = 1'b0;
    bus4.a_in = '0;
    bus4.b_in = '0;
    test_reset();
    test_basic();
    test_overflow();
    test_carry_isolation();
    test_random();
    test_stall();
    test_reset_abort();
    test_exhaustive4();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/serial_add_sequencer.md
SERIAL_ADD_SEQUENCER -- requirements
Module: serial_add_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  operand pair a_in/b_in valid.
REQ-005 SHALL have port in_ready  output  1  sequencer can accept an operand pair.
REQ-006 SHALL have port a_in  input  WIDTH  operand A, parallel.
REQ-007 SHALL have port b_in  input  WIDTH  operand B, parallel.
REQ-008 SHALL have port out_valid  output  1  sum_out/carry_out valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts result.
REQ-010 SHALL have port sum_out  output  WIDTH  result, (a_in+b_in) mod 2^WIDTH.
REQ-011 SHALL have port carry_out  output  1  carry out of MSB.
REQ-012 SHALL have port busy  output  1  high in SHIFT or DONE.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-014 SHALL drive in_ready high only in IDLE and only while rst is high.
REQ-015 SHALL, on in_valid && in_ready at an edge, load a_in/b_in into shift registers, clear bit counter and adder carry, and enter SHIFT.
REQ-016 SHALL, each SHIFT cycle, present the LSBs of both shift registers to the bit-serial adder, shift both right, and shift the sum bit into the result register from the MSB end.
REQ-017 SHALL remain in SHIFT exactly WIDTH cycles; counter width $clog2(WIDTH+1); leave SHIFT on the edge where counter reaches WIDTH-1.
REQ-018 SHALL enter DONE with out_valid=1, sum_out = full result, carry_out = final adder carry; latency from accepting edge to out_valid high is WIDTH+1 edges.
REQ-019 SHALL hold sum_out, carry_out, out_valid stable in DONE until out_valid && out_ready at an edge, then return to IDLE.
REQ-020 SHALL ignore in_valid outside IDLE (no buffering, no overwrite); minimum initiation interval WIDTH+2 cycles.
REQ-021 SHALL clear adder carry at every operation start so no carry leaks between operations.
REQ-022 SHALL keep sum_out/carry_out at their last values in IDLE; out_valid low in IDLE and SHIFT.
REQ-023 SHALL compute the adder sum and carry using only XOR/AND/OR operations (no '+' operator).

Reset
REQ-024 SHALL, while rst=0, asynchronously force state=IDLE, out_valid=0, in_ready=0, sum_out=0, carry_out=0, busy=0, counter/shift registers/carry=0.
REQ-025 SHALL abort any in-flight operation on reset with no partial result ever presented; in_ready=1 from the first cycle after rst release.

Structure
REQ-026 SHALL place the state enum type and DEFAULT_WIDTH constant in shared package serial_add_pkg.
REQ-027 SHALL instantiate one sub-module serial_add_bit: 1-bit full adder plus carry flip-flop with synchronous clear and async active-low reset.

Verification
REQ-028 Bench SHALL check WIDTH=8, a=0x5A, b=0x33 -> sum_out=0x8D, carry_out=0, out_valid exactly 9 edges after accept.
REQ-029 Bench SHALL check 0xFF+0x01 -> sum_out=0x00, carry_out=1.
REQ-030 Bench SHALL check 0xFF+0xFF (expect 0xFE, carry 1) followed by 0x00+0x00 -> 0x00, carry_out=0 (carry isolation).
REQ-031 Bench SHALL hold out_ready=0 for 5 cycles in DONE with in_valid=1, a=0x11 -> result held stable, in_ready=0, new operands not accepted.
REQ-032 Bench SHALL assert rst=0 on 3rd SHIFT cycle -> out_valid=0 immediately, in_ready=1 after release; then 0x10+0x20 -> 0x30, carry 0.
REQ-033 Bench SHALL run WIDTH=4 exhaustive 256 operand pairs with random out_ready stalls -> {carry_out,sum_out}=a+b for all.
